// File: rtl/cdam_pipe_mul_pkg.sv
// cdam_pkg: shared sizing helpers and the golden carry-disregard product
package cdam_pkg;

  // Widest operand the reference model is written for
  localparam int MAXW = 32;
  localparam int MAXR = 2 * MAXW;

  // Bits needed to encode a column count in 0..2W
  function automatic int calc_kw(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Column counts past the top of the product behave like 2W
  function automatic int clamp_k(input int k, input int w);
    return (k > 2 * w) ? 2 * w : k;
  endfunction

  // Golden result: partial products landing in a column at or above k are
  // added with full carries, those below k only toggle their own column bit.
  // The two groups never touch the same bits, so visiting order is irrelevant.
  function automatic logic [MAXR-1:0] cdam_ref(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input int k,
                                              input int w);
    logic [MAXR-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      for (int m = 0; m < w; m++) begin
        if (a[i] && b[m]) begin
          if (i + m >= k) r = r + (MAXR'(1) << (i + m));
          else            r[i + m] = ~r[i + m];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdam_pipe_mul_row_stage.sv
// cdam_row_stage: one pipeline slot that folds COUNT partial-product rows
// into the travelling accumulator and registers the result with valid/ready.
module cdam_row_stage
  import cdam_pkg::*;
#(
  parameter int W     = 8,
  parameter int KW    = 5,
  parameter int FIRST = 0,
  parameter int COUNT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [KW-1:0]  in_k,
  input  logic [2*W-1:0] in_acc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [KW-1:0]  out_k,
  output logic [2*W-1:0] out_acc
);

  logic [2*W-1:0] keep_mask;
  logic [2*W-1:0] row;
  logic [2*W-1:0] sum;

  // The slot can take a new entry when it is empty or its entry is leaving
  assign in_ready = !out_valid || out_ready;

  // Columns at or above k add normally; columns below k keep only the XOR,
  // so no carry ever leaves them (including the one into column k)
  always_comb begin
    keep_mask = {(2*W){1'b1}} << in_k;
    sum       = in_acc;
    row       = '0;
    for (int r = 0; r < COUNT; r++) begin
      row = in_b[FIRST + r] ? ({{W{1'b0}}, in_a} << (FIRST + r)) : '0;
      sum = ((sum & keep_mask) + (row & keep_mask)) | ((sum ^ row) & ~keep_mask);
    end
  end

  // Entry register; payload only loads on a real beat so a stalled result stays put
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_k     <= '0;
      out_acc   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_a   <= in_a;
        out_b   <= in_b;
        out_k   <= in_k;
        out_acc <= sum;
      end
    end
  end

endmodule

// File: rtl/cdam_pipe_mul.sv
// cdam_pipe_mul: pipelined unsigned W x W carry-disregard approximate multiplier.
// STAGES slots each add W/STAGES partial-product rows; operands and k travel along.
module cdam_pipe_mul
  import cdam_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int KW     = calc_kw(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [KW-1:0]  in_k,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_r,
  output logic [KW-1:0]  out_k
);

  localparam int ROWS = W / STAGES;

  // Index s is the input side of slot s; index STAGES is the output of the last slot
  logic           valid_p [STAGES+1];
  logic           ready_p [STAGES+1];
  logic [W-1:0]   a_p     [STAGES+1];
  logic [W-1:0]   b_p     [STAGES+1];
  logic [KW-1:0]  k_p     [STAGES+1];
  logic [2*W-1:0] acc_p   [STAGES+1];
  logic [KW-1:0]  k_in_clamped;

  // Clamp the requested column count once on entry so every slot sees a legal k
  always_comb begin
    k_in_clamped = KW'(clamp_k(int'(in_k), W));
  end

  assign valid_p[0]      = in_valid;
  assign a_p[0]          = in_a;
  assign b_p[0]          = in_b;
  assign k_p[0]          = k_in_clamped;
  assign acc_p[0]        = '0;
  assign ready_p[STAGES] = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    cdam_row_stage #(
      .W     (W),
      .KW    (KW),
      .FIRST (s * ROWS),
      .COUNT (ROWS)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_p[s]),
      .in_ready  (ready_p[s]),
      .in_a      (a_p[s]),
      .in_b      (b_p[s]),
      .in_k      (k_p[s]),
      .in_acc    (acc_p[s]),
      .out_valid (valid_p[s+1]),
      .out_ready (ready_p[s+1]),
      .out_a     (a_p[s+1]),
      .out_b     (b_p[s+1]),
      .out_k     (k_p[s+1]),
      .out_acc   (acc_p[s+1])
    );
  end

  assign in_ready  = ready_p[0] && !rst;
  assign out_valid = valid_p[STAGES];
  assign out_r     = acc_p[STAGES];
  assign out_k     = k_p[STAGES];

endmodule

// File: tb/tb_cdam_pipe_mul.sv
// tb_cdam_pipe_mul: directed checks of the 8x8 two-slot multiplier plus a
// full W=4 sweep over one, two and four slots with random backpressure
`timescale 1ns/1ps
module tb_cdam_pipe_mul;
  import cdam_pkg::*;

  localparam int W      = 8;
  localparam int STAGES = 2;
  localparam int KW     = 5;
  localparam int SW     = 4;
  localparam int NSWEEP = 9 * 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [KW-1:0] in_k;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_r;
  logic [KW-1:0] out_k;

  logic          sv_in_valid  [3];
  logic          sv_in_ready  [3];
  logic [3:0]    sv_a         [3];
  logic [3:0]    sv_b         [3];
  logic [3:0]    sv_k         [3];
  logic          sv_out_valid [3];
  logic          sv_out_ready [3];
  logic [7:0]    sv_out_r     [3];
  logic [3:0]    sv_out_k     [3];

  int checks;
  int errors;

  always #5 clk = ~clk;

  cdam_pipe_mul #(.W(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_k     (out_k)
  );

  for (genvar g = 0; g < 3; g++) begin : g_small
    cdam_pipe_mul #(.W(SW), .STAGES(1 << g)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sv_in_valid[g]),
      .in_ready  (sv_in_ready[g]),
      .in_a      (sv_a[g]),
      .in_b      (sv_b[g]),
      .in_k      (sv_k[g]),
      .out_valid (sv_out_valid[g]),
      .out_ready (sv_out_ready[g]),
      .out_r     (sv_out_r[g]),
      .out_k     (sv_out_k[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Offer one beat from posedge+1 and return at posedge+1 just after it was taken
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [KW-1:0] k);
    int waited;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_k     = k;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Push every (a, b, k<=8) through one W=4 instance and score results in order
  task automatic sweepSmall(input int g);
    logic [11:0] expq [$];
    logic [63:0] full;
    logic [11:0] head;
    int sent;
    int got;
    int cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < NSWEEP || got < NSWEEP) && cyc < 20000) begin
      sv_out_ready[g] = ($urandom_range(0, 3) != 0);
      if (sent < NSWEEP) begin
        sv_in_valid[g] = 1'b1;
        sv_a[g]        = 4'(sent % 16);
        sv_b[g]        = 4'((sent / 16) % 16);
        sv_k[g]        = 4'(sent / 256);
      end else begin
        sv_in_valid[g] = 1'b0;
      end
      @(negedge clk);
      if (sv_out_valid[g] && sv_out_ready[g]) begin
        checkOutput("sweep_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          head = expq.pop_front();
          checkOutput($sformatf("sweep_s%0d", 1 << g), 64'({sv_out_k[g], sv_out_r[g]}), 64'(head));
        end
        got++;
      end
      if (sv_in_valid[g] && sv_in_ready[g]) begin
        full = cdam_ref(MAXW'(sv_a[g]), MAXW'(sv_b[g]), int'(sv_k[g]), SW);
        expq.push_back({sv_k[g], full[7:0]});
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    sv_in_valid[g]  = 1'b0;
    sv_out_ready[g] = 1'b1;
    checkOutput($sformatf("sweep_count_s%0d", 1 << g), 64'(got), 64'(NSWEEP));
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0]  ra [20];
    logic [W-1:0]  rb [20];
    logic [KW-1:0] rk [20];
    logic [63:0]   full;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_k      = '0;
    out_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      sv_in_valid[g]  = 1'b0;
      sv_a[g]         = '0;
      sv_b[g]         = '0;
      sv_k[g]         = '0;
      sv_out_ready[g] = 1'b1;
    end

    // reset state
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("post_rst_out_r", 64'(out_r), 64'd0);
    checkOutput("post_rst_out_k", 64'(out_k), 64'd0);
    @(posedge clk);
    #1;

    // exact 255*255 and two-cycle latency
    applyStimulus(8'd255, 8'd255, 5'd0);
    checkOutput("lat_not_early", 64'(out_valid), 64'd0);
    tick();
    checkOutput("lat_valid", 64'(out_valid), 64'd1);
    checkOutput("exact_ff_r", 64'(out_r), 64'd65025);
    checkOutput("exact_ff_k", 64'(out_k), 64'd0);
    tick();
    checkOutput("lat_retired", 64'(out_valid), 64'd0);

    // approximate modes; inputs change while the beat is in flight
    applyStimulus(8'h0F, 8'h0F, 5'd4);
    in_k = 5'd0;
    in_a = 8'hAA;
    tick();
    checkOutput("k4_r", 64'(out_r), 64'd181);
    checkOutput("k4_k", 64'(out_k), 64'd4);
    applyStimulus(8'h0F, 8'h0F, 5'd16);
    tick();
    checkOutput("k16_r", 64'(out_r), 64'h55);
    checkOutput("k16_k", 64'(out_k), 64'd16);
    applyStimulus(8'h0F, 8'h0F, 5'd31);
    tick();
    checkOutput("k31_r", 64'(out_r), 64'h55);
    checkOutput("k31_clamped", 64'(out_k), 64'd16);
    applyStimulus(8'hFF, 8'hFF, 5'd8);
    tick();
    checkOutput("k8_ff_r", 64'(out_r), 64'd63317);
    tick();

    // back-to-back stream, one result per cycle in order
    for (int i = 0; i < 20; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rk[i] = KW'($urandom_range(0, 31));
    end
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        in_valid = 1'b1;
        in_a     = ra[i];
        in_b     = rb[i];
        in_k     = rk[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 20) checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
      if (i >= 2) begin
        full = cdam_ref(MAXW'(ra[i-2]), MAXW'(rb[i-2]), clamp_k(int'(rk[i-2]), W), W);
        checkOutput("b2b_valid", 64'(out_valid), 64'd1);
        checkOutput("b2b_r", 64'(out_r), full);
        checkOutput("b2b_k", 64'(out_k), 64'(clamp_k(int'(rk[i-2]), W)));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // stall: two entries fill the pipe, the third waits for the first to retire
    out_ready = 1'b0;
    applyStimulus(8'd3, 8'd5, 5'd0);
    applyStimulus(8'd200, 8'd100, 5'd0);
    in_valid = 1'b1;
    in_a     = 8'h0F;
    in_b     = 8'h0F;
    in_k     = 5'd4;
    @(negedge clk);
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_r", 64'(out_r), 64'd15);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_hold_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_hold_r", 64'(out_r), 64'd15);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("stall_first_r", 64'(out_r), 64'd15);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("stall_second_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_second_r", 64'(out_r), 64'd20000);
    tick();
    checkOutput("stall_third_r", 64'(out_r), 64'd181);
    checkOutput("stall_third_k", 64'(out_k), 64'd4);
    tick();
    checkOutput("stall_drained", 64'(out_valid), 64'd0);

    // a gap between beats must close up while the output is blocked
    out_ready = 1'b0;
    applyStimulus(8'd12, 8'd12, 5'd0);
    tick();
    tick();
    applyStimulus(8'd10, 8'd10, 5'd0);
    in_valid = 1'b1;
    in_a     = 8'd1;
    in_b     = 8'd1;
    in_k     = 5'd0;
    @(negedge clk);
    checkOutput("bubble_full", 64'(in_ready), 64'd0);
    checkOutput("bubble_first_r", 64'(out_r), 64'd144);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bubble_second_valid", 64'(out_valid), 64'd1);
    checkOutput("bubble_second_r", 64'(out_r), 64'd100);
    tick();
    checkOutput("bubble_drained", 64'(out_valid), 64'd0);

    // reset with two beats in flight discards both
    out_ready = 1'b0;
    applyStimulus(8'd7, 8'd9, 5'd3);
    applyStimulus(8'd11, 8'd13, 5'd3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_out_r", 64'(out_r), 64'd0);
    checkOutput("rst_mid_out_k", 64'(out_k), 64'd0);
    checkOutput("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_no_stale", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // exhaustive W=4 sweeps for one, two and four slots
    sweepSmall(0);
    sweepSmall(1);
    sweepSmall(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
